fetch_pc_queue: RTL and testbench
=================================

Name: fetch_pc_queue

Overview:
Parametrised successor to the single-register PC fetch stage. Generates sequential fetch addresses toward the instruction memory port with a valid/ready request handshake and in-order responses. Buffers up to QDEPTH fetched instructions with their PCs for decode. Handles exception and branch redirects by flushing queued entries and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'hbfc00000, PC value after reset.
ADDR_W, 32, PC/address width.
DATA_W, 32, instruction width.
QDEPTH, 4, queue entries; also the maximum number of in-flight plus undelivered fetches; power of 2, >= 2.

Ports:
Clk  in  1  clock, rising edge.
Clr_n  in  1  asynchronous active-low reset.
is_exception  in  1  exception redirect strobe.
exception_new_pc  in  ADDR_W  exception target.
redirect_valid  in  1  branch/jump redirect strobe.
redirect_pc  in  ADDR_W  branch target.
stall  in  1  suppresses new requests; queue output is unaffected.
im_req  out  1  fetch request valid.
im_addr  out  ADDR_W  fetch address.
im_ready  in  1  memory accepts request.
im_rvalid  in  1  response valid; responses are in request order.
im_rdata  in  DATA_W  instruction data.
out_valid  out  1  head entry valid.
out_pc  out  ADDR_W  head entry PC.
out_instr  out  DATA_W  head entry instruction.
out_ready  in  1  decode consumes the head entry.

Behaviour:
- Reset (Clr_n=0, async): fetch_pc=RESET_PC, queue empty, drop_cnt=0, im_req=0, out_valid=0, out_pc=0, out_instr=0. First im_req is asserted in the first cycle after deassertion.
- im_addr=fetch_pc. Low 2 bits of every redirect target are forced to 0.
- Issue condition: im_req = !stall && !redir_now && (alloc_cnt + drop_cnt < QDEPTH), where redir_now = is_exception | redirect_valid.
- On im_req && im_ready: allocate a tail entry {pc=fetch_pc, filled=0}, then fetch_pc += 4 with mod 2^ADDR_W wrap. im_addr is held stable while im_req=1 and im_ready=0.
- Response: if drop_cnt>0, discard the response and decrement drop_cnt. Otherwise write im_rdata into the oldest unfilled entry and set filled=1. A response with no unfilled entry and drop_cnt=0 is a protocol error (assertion).
- Output: out_valid = head.filled. Pop on out_valid && out_ready. A head filled in cycle N is visible in cycle N+1 (one-cycle response-to-output latency). Pop, allocate, and fill may all occur in the same cycle.
- Redirect in cycle N:
  - Priority: is_exception over redirect_valid.
  - fetch_pc is set to the target.
  - All queue entries are flushed, including an entry popping that cycle.
  - drop_cnt <= drop_cnt + (unfilled entries) - (1 if a response arrives in cycle N and is consumed by the drop or fill).
  - im_req=0 in cycle N. First request to the target is issued in cycle N+1.
  - out_valid=0 in cycle N+1.
- Full: alloc_cnt + drop_cnt == QDEPTH forces im_req=0. Requests resume the cycle after a pop or drop frees a credit.
- stall=1 blocks allocation only. Responses and pops continue.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_fetch_cnt[31:0] (accepted requests) and perf_drop_cnt[31:0] (discarded responses plus flushed filled entries). Both are free-running, wrap at 2^32, and reset to 0. When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Release reset, im_ready=1, response 1 cycle after accept, out_ready=1 -> im_addr sequence bfc00000, bfc00004, bfc00008; out_pc follows in the same order with matching out_instr.
2. out_ready=0, im_ready=1, immediate responses -> exactly 4 requests accepted, then im_req=0. Raise out_ready -> one new request per pop.
3. 2 requests outstanding (unfilled), redirect_valid with redirect_pc=80001000 -> next 2 responses discarded, out_valid stays 0, next im_addr=80001000.
4. is_exception (exception_new_pc=bfc00380) together with redirect_valid (80002000) -> im_addr=bfc00380 in the following cycle.
5. im_ready=0 for 3 cycles -> im_req stays 1 and im_addr stays bfc00000. Redirect target 80000003 -> im_addr=80000000.
6. Assert Clr_n=0 mid-burst, asynchronously between edges -> im_req=0 and out_valid=0 immediately. After release, im_addr=bfc00000 and no stale responses are delivered (bench issues none).

Source files
------------

// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: sequential PC fetch stage with a QDEPTH-entry instruction
// queue between the instruction memory port and decode.
//
// Ports
//   Clk, Clr_n                        clock (rising edge), async active-low reset
//   is_exception, exception_new_pc    exception redirect (wins over branch redirect)
//   redirect_valid, redirect_pc       branch/jump redirect
//   stall                             blocks new fetch requests only
//   im_req, im_addr, im_ready         fetch request handshake
//   im_rvalid, im_rdata               in-order fetch responses
//   out_valid, out_pc, out_instr,
//   out_ready                         head-of-queue handshake toward decode
//
// Build option
//   FETCH_PERF_CNT_EN  adds perf_fetch_cnt (accepted requests) and
//                      perf_drop_cnt (discarded responses + flushed filled entries).
//
// Queue bookkeeping: entries are allocated and filled strictly in order, so
// the filled entries always form a contiguous run starting at the head. Only
// head, alloc_cnt and fill_cnt are tracked; the tail and fill slots are offsets
// from the head. drop_cnt counts responses still owed for flushed requests.
module fetch_pc_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic              is_exception,
  input  logic [ADDR_W-1:0] exception_new_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ready,
  input  logic              im_rvalid,
  input  logic [DATA_W-1:0] im_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  input  logic              out_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(QDEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              run_q, run_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [CNT_W-1:0]  alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0] pc_mem_q [QDEPTH];
  logic [ADDR_W-1:0] pc_mem_d [QDEPTH];
  logic [DATA_W-1:0] instr_mem_q [QDEPTH];
  logic [DATA_W-1:0] instr_mem_d [QDEPTH];

  logic              redir_now;
  logic [ADDR_W-1:0] redir_target;
  logic [CNT_W:0]    credit_used;
  logic              accept, pop, rsp_drop, rsp_fill;
  logic [PTR_W-1:0]  tail_idx, fill_idx;

  assign redir_now    = is_exception | redirect_valid;
  assign redir_target = (is_exception ? exception_new_pc : redirect_pc) & ~ADDR_W'(3);
  // Owed-but-discarded responses still occupy a credit until they return.
  assign credit_used  = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};

  // run_q keeps im_req low through reset and the release cycle.
  assign im_req    = run_q & ~stall & ~redir_now & (credit_used < DEPTH_C);
  assign im_addr   = fetch_pc_q;
  assign accept    = im_req & im_ready;
  assign out_valid = (fill_cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign rsp_drop  = im_rvalid & (drop_cnt_q != '0);
  assign rsp_fill  = im_rvalid & (drop_cnt_q == '0) & (fill_cnt_q != alloc_cnt_q);
  assign tail_idx  = head_q + alloc_cnt_q[PTR_W-1:0];
  assign fill_idx  = head_q + fill_cnt_q[PTR_W-1:0];

  assign out_pc    = out_valid ? pc_mem_q[head_q]    : '0;
  assign out_instr = out_valid ? instr_mem_q[head_q] : '0;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    run_d       = 1'b1;
    head_d      = head_q;
    alloc_cnt_d = alloc_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (accept) begin
      pc_mem_d[tail_idx] = fetch_pc_q;
      fetch_pc_d         = fetch_pc_q + ADDR_W'(4);
    end
    if (rsp_fill) begin
      instr_mem_d[fill_idx] = im_rdata;
    end

    if (redir_now) begin
      // Flush everything, including a head popping this cycle. Each unfilled
      // entry still has a response on its way, except one arriving right now.
      fetch_pc_d  = redir_target;
      alloc_cnt_d = '0;
      fill_cnt_d  = '0;
      drop_cnt_d  = drop_cnt_q + (alloc_cnt_q - fill_cnt_q)
                    - CNT_W'(rsp_drop | rsp_fill);
    end else begin
      head_d      = head_q + PTR_W'(pop);
      alloc_cnt_d = alloc_cnt_q + CNT_W'(accept) - CNT_W'(pop);
      fill_cnt_d  = fill_cnt_q + CNT_W'(rsp_fill) - CNT_W'(pop);
      drop_cnt_d  = drop_cnt_q - CNT_W'(rsp_drop);
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      fetch_pc_q  <= RESET_PC;
      run_q       <= 1'b0;
      head_q      <= '0;
      alloc_cnt_q <= '0;
      fill_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      run_q       <= run_d;
      head_q      <= head_d;
      alloc_cnt_q <= alloc_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_drop_q, perf_drop_d;

  // A response filling an entry in the redirect cycle is flushed with it.
  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(accept);
    perf_drop_d  = perf_drop_q + 32'(rsp_drop)
                   + (redir_now ? (32'(fill_cnt_q) + 32'(rsp_fill)) : 32'd0);
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_drop_cnt  = perf_drop_q;
`else
  // No performance counters in this build.
`endif

  // A response must belong either to a flushed request or an unfilled entry.
  rsp_orphan_a: assert property (@(posedge Clk) disable iff (!Clr_n)
    im_rvalid |-> ((drop_cnt_q != '0) || (fill_cnt_q != alloc_cnt_q)));

endmodule

// File: tb/tb_fetch_pc_queue.sv
module tb_fetch_pc_queue;

  localparam int QD = 4;
  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        Clk, Clr_n;
  logic        is_exception, redirect_valid, stall;
  logic [31:0] exception_new_pc, redirect_pc;
  logic        im_req, im_ready, im_rvalid;
  logic [31:0] im_addr, im_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  fetch_pc_queue #(.ADDR_W(32), .DATA_W(32), .QDEPTH(QD), .RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Clr_n(Clr_n),
    .is_exception(is_exception), .exception_new_pc(exception_new_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;

  exp_t        sb[$];        // expected decode stream (live entries)
  pend_t       pending[$];   // memory model: accepted requests awaiting response
  logic [31:0] acc_log[$];
  logic [31:0] model_pc;
  int          epoch, cyc;
  logic        run_m;
  int          checks, errors;
  logic        mon_post_redir;

  int k_stall, k_ready, k_oready, k_lat_min, k_lat_max, k_redir;
  logic        f_go, f_exc, f_rv;
  logic [31:0] f_epc, f_rpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h1234abcd;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // One clock: drive at negedge, evaluate the coming edge 1ns later.
  task automatic cycle();
    int   stale;
    logic rv, redir, exp_req;
    @(negedge Clk);
    cyc++;
    stall     = ($urandom_range(0, 99) < k_stall);
    im_ready  = ($urandom_range(0, 99) < k_ready);
    out_ready = ($urandom_range(0, 99) < k_oready);
    is_exception = 1'b0; redirect_valid = 1'b0;
    exception_new_pc = $urandom(); redirect_pc = $urandom();
    if (f_go) begin
      is_exception = f_exc; redirect_valid = f_rv;
      exception_new_pc = f_epc; redirect_pc = f_rpc;
      f_go = 1'b0;
    end else if ($urandom_range(0, 99) < k_redir) begin
      is_exception   = 1'($urandom_range(0, 1));
      redirect_valid = !is_exception || 1'($urandom_range(0, 1));
    end
    rv = 1'b0;
    if (pending.size() > 0) rv = (pending[0].due <= cyc);
    im_rvalid = rv;
    im_rdata  = rv ? mem_word(pending[0].addr) : $urandom();
    #1;
    stale = 0;
    foreach (pending[i]) if (pending[i].epoch != epoch) stale++;
    redir   = is_exception | redirect_valid;
    exp_req = run_m && !stall && !redir && ((sb.size() + stale) < QD);
    chk("im_req", 32'(im_req), 32'(exp_req));
    if (exp_req) chk("im_addr", im_addr, model_pc);
    if (exp_req && im_ready) begin
      sb.push_back('{model_pc, mem_word(model_pc)});
      pending.push_back('{model_pc, epoch, cyc + 1 + $urandom_range(k_lat_min, k_lat_max)});
      acc_log.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
    if (rv) void'(pending.pop_front());
    if (redir) begin
      epoch++;
      sb.delete();
      model_pc = (is_exception ? exception_new_pc : redirect_pc) & ~32'd3;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic force_redir(input logic exc, input logic [31:0] epc,
                             input logic rvl, input logic [31:0] rpc);
    f_go = 1'b1; f_exc = exc; f_epc = epc; f_rv = rvl; f_rpc = rpc;
  endtask

  task automatic do_reset();
    Clr_n = 1'b0;
    is_exception = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    im_ready = 1'b0; im_rvalid = 1'b0; out_ready = 1'b0;
    exception_new_pc = '0; redirect_pc = '0; im_rdata = '0;
    sb.delete(); pending.delete(); acc_log.delete();
    model_pc = RST_PC; run_m = 1'b0; f_go = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_im_addr", im_addr, RST_PC);
    Clr_n = 1'b1;
    #1;
    chk("release_im_req", 32'(im_req), 32'd0);
    run_m = 1'b1;
  endtask

  task automatic knobs(input int s, input int r, input int o,
                       input int lmin, input int lmax, input int rd);
    k_stall = s; k_ready = r; k_oready = o; k_lat_min = lmin; k_lat_max = lmax; k_redir = rd;
  endtask

  // Scoreboard monitor: compares whatever decode consumes.
  always begin
    @(negedge Clk);
    #2;
    if (Clr_n !== 1'b1) begin
      mon_post_redir = 1'b0;
    end else begin
      if (mon_post_redir) chk("out_valid_after_redirect", 32'(out_valid), 32'd0);
      if (out_valid && out_ready && !(is_exception || redirect_valid)) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
        end
      end
      mon_post_redir = is_exception | redirect_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0; epoch = 0; cyc = 0; mon_post_redir = 1'b0;
    knobs(0, 100, 100, 0, 0, 0);

    // Straight-line fetch, responses one cycle after accept.
    do_reset();
    run(12);
    if (acc_log.size() >= 3) begin
      chk("seq_addr0", acc_log[0], 32'hbfc00000);
      chk("seq_addr1", acc_log[1], 32'hbfc00004);
      chk("seq_addr2", acc_log[2], 32'hbfc00008);
    end else fail_now("seq_too_few_accepts");

    // Decode blocked: exactly QDEPTH requests, then credits run out.
    do_reset();
    knobs(0, 100, 0, 0, 0, 0);
    run(10);
    chk("full_accepts", 32'(acc_log.size()), 32'(QD));
    chk("full_im_req", 32'(im_req), 32'd0);
    knobs(0, 100, 100, 0, 0, 0);
    run(10);

    // Redirect with two unfilled requests in flight.
    do_reset();
    knobs(0, 100, 100, 6, 6, 0);
    n = 0;
    while (acc_log.size() < 2 && n < 50) begin cycle(); n++; end
    if (acc_log.size() < 2) fail_now("redirect_setup_timeout");
    k_ready = 0;
    force_redir(1'b0, 32'h0, 1'b1, 32'h80001000);
    cycle();
    acc_log.delete();
    knobs(0, 100, 100, 0, 0, 0);
    run(12);
    if (acc_log.size() > 0) chk("redirect_target", acc_log[0], 32'h80001000);
    else fail_now("redirect_no_accept");

    // Exception wins over a simultaneous branch redirect.
    force_redir(1'b1, 32'hbfc00380, 1'b1, 32'h80002000);
    cycle();
    acc_log.delete();
    run(4);
    if (acc_log.size() > 0) chk("exception_priority", acc_log[0], 32'hbfc00380);
    else fail_now("exception_no_accept");

    // Memory back-pressure holds the address; misaligned target is aligned.
    do_reset();
    knobs(0, 0, 100, 0, 0, 0);
    run(4);
    chk("hold_im_req", 32'(im_req), 32'd1);
    chk("hold_im_addr", im_addr, 32'hbfc00000);
    knobs(0, 100, 100, 0, 0, 0);
    force_redir(1'b0, 32'h0, 1'b1, 32'h80000003);
    cycle();
    acc_log.delete();
    run(4);
    if (acc_log.size() > 0) chk("aligned_target", acc_log[0], 32'h80000000);
    else fail_now("aligned_no_accept");

    // Randomized traffic in several flavours.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      knobs($urandom_range(0, 30), $urandom_range(30, 100), $urandom_range(20, 100),
            0, $urandom_range(0, 3), $urandom_range(0, 8));
      run(500);
    end

    // Asynchronous reset in the middle of a burst.
    knobs(0, 100, 50, 0, 2, 0);
    run(6);
    @(posedge Clk);
    #3;
    Clr_n = 1'b0;
    #1;
    chk("async_rst_im_req", 32'(im_req), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    do_reset();
    knobs(0, 100, 100, 0, 0, 0);
    run(10);
    if (acc_log.size() > 0) chk("post_rst_addr", acc_log[0], RST_PC);
    else fail_now("post_rst_no_accept");

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
